// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx -- PS/2 keyboard receiver (device-to-host frames)
//
// Oversamples the keyboard clock/data pins in the clk domain, deframes 11-bit
// PS/2 frames (start, 8 data LSB-first, odd parity, stop) and keeps the two
// most recently received scan-code bytes in a 16-bit window.
//
// Parameters:
//   SYNC_STAGES    : synchronizer depth on kb_clk and kb_data (>= 2)
//   TIMEOUT_CYCLES : clk cycles without a kb_clk falling edge, mid-frame,
//                    before the partial frame is abandoned
//
// Ports:
//   clk        in   system clock, rising edge
//   kb_clk     in   PS/2 clock pin (asynchronous, idle high)
//   kb_data    in   PS/2 data pin (asynchronous, idle high)
//   buffer_out out  {previous byte, latest byte}; [7:0] is the newest code
//   rst        in   asynchronous active-high reset
//
// Build option:
//   PS2_PARITY_CHECK_EN -- when defined, frames with bad odd parity or a stop
//   bit of 0 are dropped; when undefined every frame reaching STOP is kept.
// -----------------------------------------------------------------------------
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        kb_clk,
  input  logic        kb_data,
  output logic [15:0] buffer_out,
  input  logic        rst
);

  localparam int             WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [WD_W-1:0]        r_wdog;
  logic [15:0]            r_buffer;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;
  logic                   w_timeout;
  logic                   w_frame_ok;
  logic                   w_accept;

`ifdef PS2_PARITY_CHECK_EN
  logic                   r_parity;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    odd_parity_ok = ^{data, par};
  endfunction

  // Parity bit is only needed when frames are being qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if ((r_state == ST_PARITY) && w_fall) begin
      r_parity <= w_data_s;
    end
  end

  // Stop bit is judged live, in the same cycle its edge is detected.
  assign w_frame_ok = odd_parity_ok(r_shift, r_parity) & w_data_s;
`else
  assign w_frame_ok = 1'b1;
`endif

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s   = r_data_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign w_timeout  = (r_wdog == WD_MAX);
  assign buffer_out = r_buffer;

  // Pin synchronizers plus the extra kb_clk stage for edge detection; they
  // reset to the idle line level so reset release cannot fake an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= {SYNC_STAGES{1'b1}};
      r_data_sync <= {SYNC_STAGES{1'b1}};
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], kb_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], kb_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame-accept decode. A real edge wins over a watchdog
  // expiry landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_data_s) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_fall) begin
          w_state_nxt = ST_STOP;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_accept    = w_frame_ok;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit counter, LSB-first shift register and the 2-byte output window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_buffer  <= 16'h0000;
    end else begin
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if ((r_state == ST_DATA) && w_fall) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if ((r_state == ST_DATA) && w_fall) begin
        r_shift <= {w_data_s, r_shift[7:1]};
      end
      if (w_accept) begin
        r_buffer <= {r_buffer[7:0], r_shift};
      end
    end
  end

  // Mid-frame watchdog: idle in IDLE, restarted by every kb_clk falling edge,
  // saturates at the limit so the FSM sees a stable expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if ((r_state == ST_IDLE) || w_fall) begin
      r_wdog <= '0;
    end else if (!w_timeout) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

  logic        clk;
  logic        kb_clk;
  logic        kb_data;
  logic [15:0] buffer_out;
  logic        rst;

  int n_tests;
  int n_fail;

  ps2_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)) dut (
    .clk        (clk),
    .kb_clk     (kb_clk),
    .kb_data    (kb_data),
    .buffer_out (buffer_out),
    .rst        (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        par_flip;
    logic        stop;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame bits in wire order: start, d0..d7, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic pf, input logic st);
    logic p;
    p = (~^d) ^ pf;
    make_frame = {st, p, d, 1'b0};
  endfunction

  // Drive the first nbits of a frame, kb_clk period 20 clk cycles.
  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); kb_data = fr[i];
      repeat (5) @(negedge clk);
      kb_clk = 1'b0;
      repeat (10) @(negedge clk);
      kb_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    @(negedge clk); kb_data = 1'b1;
  endtask

  initial begin
    logic [10:0] fr;
    n_tests = 0;
    n_fail  = 0;
    kb_clk  = 1'b1;
    kb_data = 1'b1;
    rst     = 1'b1;

    // Table: frames applied back to back after a reset.
    vecs[0] = '{8'hF0, 1'b0, 1'b1, 16'h00F0};
    vecs[1] = '{8'h6C, 1'b0, 1'b1, 16'hF06C};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 16'h6C1C};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 16'h1C00};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 16'h00FF};
    vecs[5] = '{8'hA5, 1'b0, 1'b1, 16'hFFA5};
`ifdef PS2_PARITY_CHECK_EN
    vecs[6] = '{8'h1C, 1'b1, 1'b1, 16'hFFA5};
    vecs[7] = '{8'h3C, 1'b0, 1'b0, 16'hFFA5};
    vecs[8] = '{8'h81, 1'b0, 1'b1, 16'hA581};
`else
    vecs[6] = '{8'h1C, 1'b1, 1'b1, 16'hA51C};
    vecs[7] = '{8'h3C, 1'b0, 1'b0, 16'h1C3C};
    vecs[8] = '{8'h81, 1'b0, 1'b1, 16'h3C81};
`endif

    // Reset behaviour.
    repeat (5) @(negedge clk);
    check("reset_held", buffer_out, 16'h0000);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("reset_idle", buffer_out, 16'h0000);

    // Single 0x1C frame with exact update latency on the 11th edge.
    fr = make_frame(8'h1C, 1'b0, 1'b1);
    send_bits(fr, 10);
    @(negedge clk); kb_data = fr[10];
    repeat (5) @(negedge clk);
    kb_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("latency_early", buffer_out, 16'h0000);
    @(posedge clk);
    #1 check("latency_1c", buffer_out, 16'h001C);
    repeat (8) @(negedge clk);
    kb_clk = 1'b1;
    repeat (30) @(negedge clk);
    check("hold_1c", buffer_out, 16'h001C);

    // Table-driven frames from a fresh reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      send_bits(make_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop), 11);
      repeat (30) @(negedge clk);
      check($sformatf("vec%0d", i), buffer_out, vecs[i].exp);
    end

    // Timeout: start + 4 data bits, long stall, then a clean 0x6C frame.
    send_bits(make_frame(8'hFF, 1'b0, 1'b1), 5);
    repeat (4200) @(negedge clk);
    check("timeout_hold", buffer_out, vecs[8].exp);
    send_bits(make_frame(8'h6C, 1'b0, 1'b1), 11);
    repeat (30) @(negedge clk);
    check("timeout_6c", buffer_out, {vecs[8].exp[7:0], 8'h6C});

    // Mid-frame reset after 6 bits, then a full 0x1C frame.
    send_bits(make_frame(8'hF0, 1'b0, 1'b1), 6);
    #2 rst = 1'b1;
    #1 check("midreset_async", buffer_out, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
    repeat (30) @(negedge clk);
    check("midreset_1c", buffer_out, 16'h001C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
